mem_line_responder: RTL and testbench

Main-memory responder for the cache's memory-side port. It accepts one line-sized request at a time from the cache, holds a byte-maskable backing store, and answers reads with a four-beat burst. It absorbs write data as four masked beats. It sits between the cache and the testbench or top level, acting as the target end of the `mem_req_*` / `mem_resp_*` handshake the cache drives.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_line_responder_if.sv | 34 +++
 rtl/mem_line_store.sv | 26 ++
 rtl/mem_line_responder.sv | 128 ++++++++++++
 tb/tb_mem_line_responder.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for mem_line_responder: beat count, FSM encoding,
// and the backpressure LFSR seed/taps used when MEM_RESP_BACKPRESSURE_EN is defined.
package mem_pkg;

  localparam int MEM_BEATS = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_BURST = 2'd2,
    ST_WR_DATA  = 2'd3
  } mem_state_t;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_line_responder_if.sv
// Memory-side port between the cache (master) and mem_line_responder (slave).
interface mem_line_responder_if #(
  parameter int MEM_DATA_BITS = 128,
  parameter int MEM_ADDR_BITS = 28
);

  // Handshakes: a request transfers on a cycle with mem_req_val & mem_req_rdy, a
  // write beat on mem_req_data_valid & mem_req_data_ready; a master holds valid
  // and payload stable until the transfer. mem_resp_val has no ready: the master
  // must sink every read beat in the cycle it is presented.
  logic                       mem_req_val;
  logic                       mem_req_rdy;
  logic [MEM_ADDR_BITS-1:0]   mem_req_addr;
  logic                       mem_req_rw;
  logic                       mem_req_data_valid;
  logic                       mem_req_data_ready;
  logic [MEM_DATA_BITS-1:0]   mem_req_data_bits;
  logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask;
  logic                       mem_resp_val;
  logic [MEM_DATA_BITS-1:0]   mem_resp_data;

  modport master (
    output mem_req_val, mem_req_addr, mem_req_rw,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_data
  );

  modport slave (
    input  mem_req_val, mem_req_addr, mem_req_rw,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_rdy, mem_req_data_ready, mem_resp_val, mem_resp_data
  );

endinterface

// File: rtl/mem_line_store.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
module mem_line_store #(
  parameter int DATA_BITS  = 128,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                   clk,
  input  logic [DEPTH_LOG2-1:0]  i_addr,
  input  logic [DATA_BITS/8-1:0] i_wr_be,
  input  logic [DATA_BITS-1:0]   i_wr_data,
  output logic [DATA_BITS-1:0]   o_rd_data
);

  logic [DATA_BITS-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_BITS-1:0] r_rd_data;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_BITS/8; b++) begin
      if (i_wr_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wr_data[b*8 +: 8];
    end
    r_rd_data <= r_mem[i_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mem_line_responder.sv
// Line-granular memory responder: 4-beat read bursts after READ_LATENCY, 4 masked
// write beats. Optional ready backpressure under `MEM_RESP_BACKPRESSURE_EN`.
module mem_line_responder
  import mem_pkg::*;
#(
  parameter int MEM_DATA_BITS = 128,
  parameter int MEM_ADDR_BITS = 28,
  parameter int DEPTH_LOG2    = 12,
  parameter int READ_LATENCY  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_line_responder_if.slave  mem,
  output mem_state_t           o_dbg_state
);

  localparam int MASK_BITS = MEM_DATA_BITS/8;

  mem_state_t               r_state;
  mem_state_t               w_next_state;
  logic [DEPTH_LOG2-3:0]    r_line;
  logic [1:0]               r_beat;
  logic [3:0]               r_lat;
  logic                     r_alive;
  logic                     w_stall;
  logic                     w_fire;
  logic                     w_data_fire;
  logic                     w_last_beat;
  logic [DEPTH_LOG2-1:0]    w_ram_addr;
  logic [MASK_BITS-1:0]     w_wr_be;
  logic [MEM_DATA_BITS-1:0] w_rd_data;
  logic                     w_unused_addr;

  // Address bits above the storage depth alias; the low two select nothing.
  assign w_unused_addr = ^{mem.mem_req_addr[MEM_ADDR_BITS-1:DEPTH_LOG2],
                           mem.mem_req_addr[1:0]};

`ifdef MEM_RESP_BACKPRESSURE_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  // r_alive keeps mem_req_rdy low while reset is held without a reset-to-output path.
  assign mem.mem_req_rdy        = r_alive & (r_state == ST_IDLE) & ~w_stall;
  assign mem.mem_req_data_ready = (r_state == ST_WR_DATA) & ~w_stall;
  assign mem.mem_resp_val       = (r_state == ST_RD_BURST);
  assign mem.mem_resp_data      = (r_state == ST_RD_BURST) ? w_rd_data : '0;
  assign o_dbg_state            = r_state;

  assign w_fire      = mem.mem_req_val & mem.mem_req_rdy;
  assign w_data_fire = mem.mem_req_data_valid & mem.mem_req_data_ready;
  assign w_last_beat = (r_beat == 2'(MEM_BEATS-1));
  assign w_wr_be     = w_data_fire ? mem.mem_req_data_mask : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          if (mem.mem_req_rw)         w_next_state = ST_WR_DATA;
          else if (READ_LATENCY == 1) w_next_state = ST_RD_BURST;
          else                        w_next_state = ST_RD_WAIT;
        end
      end
      // r_lat reaching 0 on this edge puts beat 0 READ_LATENCY cycles after the fire.
      ST_RD_WAIT:  if (r_lat == 4'd1) w_next_state = ST_RD_BURST;
      ST_RD_BURST: if (w_last_beat) w_next_state = ST_IDLE;
      ST_WR_DATA:  if (w_data_fire && w_last_beat) w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Reads are addressed one beat ahead so the registered RAM output lines up.
  always_comb begin
    w_ram_addr = {mem.mem_req_addr[DEPTH_LOG2-1:2], 2'b00};
    case (r_state)
      ST_RD_WAIT:  w_ram_addr = {r_line, 2'b00};
      ST_RD_BURST: w_ram_addr = {r_line, r_beat + 2'd1};
      ST_WR_DATA:  w_ram_addr = {r_line, r_beat};
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_line  <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_alive <= 1'b1;
      if (w_fire) begin
        r_line <= mem.mem_req_addr[DEPTH_LOG2-1:2];
        r_beat <= '0;
        r_lat  <= 4'(READ_LATENCY - 1);
      end else begin
        case (r_state)
          ST_RD_WAIT:  r_lat  <= r_lat - 4'd1;
          ST_RD_BURST: r_beat <= r_beat + 2'd1;
          ST_WR_DATA:  if (w_data_fire) r_beat <= r_beat + 2'd1;
          default:     ;
        endcase
      end
    end
  end

  mem_line_store #(
    .DATA_BITS  (MEM_DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_store (
    .clk       (clk),
    .i_addr    (w_ram_addr),
    .i_wr_be   (w_wr_be),
    .i_wr_data (mem.mem_req_data_bits),
    .o_rd_data (w_rd_data)
  );

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: directed line tests, reset abort, then random
// reads/writes against a beat-array model of the backing store.
module tb_mem_line_responder;
  import mem_pkg::*;

  localparam int RL = 4;

  logic       clk = 1'b0;
  logic       reset;
  mem_state_t dbg_state;

  mem_line_responder_if #(.MEM_DATA_BITS(128), .MEM_ADDR_BITS(28)) mif ();

  mem_line_responder #(
    .MEM_DATA_BITS (128),
    .MEM_ADDR_BITS (28),
    .DEPTH_LOG2    (12),
    .READ_LATENCY  (RL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (mif),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] model_mem [0:4095];
  logic [127:0] exp_q [$];
  logic [127:0] wr_data [4];
  logic [15:0]  wr_mask [4];
  logic [9:0]   pool [8];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [27:0] addr, input logic rw);
    bit got = 0;
    @(posedge clk); #1;
    mif.mem_req_val  = 1'b1;
    mif.mem_req_addr = addr;
    mif.mem_req_rw   = rw;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (mif.mem_req_rdy) begin got = 1; break; end
    end
    check_eq("req_accept", 128'(got), 128'd1);
    @(posedge clk); #1;
    mif.mem_req_val = 1'b0;
  endtask

  task automatic do_write(input logic [27:0] addr, input int n_beats, input int gap);
    int viol = 0;
    issue(addr, 1'b1);
    for (int b = 0; b < n_beats; b++) begin
      bit got = 0;
      repeat (gap) begin
        @(negedge clk);
        if (mif.mem_req_rdy) viol++;
        @(posedge clk); #1;
      end
      mif.mem_req_data_valid = 1'b1;
      mif.mem_req_data_bits  = wr_data[b];
      mif.mem_req_data_mask  = wr_mask[b];
      for (int w = 0; w < 200; w++) begin
        @(negedge clk);
        if (mif.mem_req_rdy) viol++;
        if (mif.mem_req_data_ready) begin got = 1; break; end
      end
      check_eq("wr_accept", 128'(got), 128'd1);
      @(posedge clk); #1;
      mif.mem_req_data_valid = 1'b0;
      if (got) begin
        for (int k = 0; k < 16; k++)
          if (wr_mask[b][k]) model_mem[{addr[11:2], b[1:0]}][k*8 +: 8] = wr_data[b][k*8 +: 8];
      end
    end
    check_eq("wr_rdy_low", 128'(viol), 128'd0);
`ifndef MEM_RESP_BACKPRESSURE_EN
    if (n_beats == 4) begin
      @(negedge clk);
      check_eq("wr_rdy_ret", 128'(mif.mem_req_rdy), 128'd1);
    end
`endif
  endtask

  task automatic do_read(input logic [27:0] addr);
    int early = 0;
    for (int b = 0; b < 4; b++) exp_q.push_back(model_mem[{addr[11:2], b[1:0]}]);
    issue(addr, 1'b0);
    // Bench sits at fire edge + #1; the k-th following negedge is cycle T+k.
    for (int k = 1; k < RL; k++) begin
      @(negedge clk);
      if (mif.mem_resp_val || mif.mem_resp_data != '0) early++;
    end
    check_eq("rd_early", 128'(early), 128'd0);
    for (int b = 0; b < 4; b++) begin
      logic [127:0] exp;
      @(negedge clk);
      exp = exp_q.pop_front();
      check_eq("rd_val", 128'(mif.mem_resp_val), 128'd1);
      check_eq("rd_data", mif.mem_resp_data, exp);
    end
    @(negedge clk);
    check_eq("rd_val_end", 128'(mif.mem_resp_val), 128'd0);
`ifndef MEM_RESP_BACKPRESSURE_EN
    check_eq("rd_rdy_ret", 128'(mif.mem_req_rdy), 128'd1);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset                  = 1'b0;
    mif.mem_req_val        = 1'b0;
    mif.mem_req_addr       = '0;
    mif.mem_req_rw         = 1'b0;
    mif.mem_req_data_valid = 1'b0;
    mif.mem_req_data_bits  = '0;
    mif.mem_req_data_mask  = '0;

    // Reset and the first idle cycle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdy", 128'(mif.mem_req_rdy), 128'd0);
    check_eq("rst_resp_val", 128'(mif.mem_resp_val), 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
`ifndef MEM_RESP_BACKPRESSURE_EN
    check_eq("idle_rdy", 128'(mif.mem_req_rdy), 128'd1);
`endif
    check_eq("idle_data_ready", 128'(mif.mem_req_data_ready), 128'd0);
    check_eq("idle_resp_val", 128'(mif.mem_resp_val), 128'd0);
    check_eq("idle_resp_data", mif.mem_resp_data, 128'd0);
    check_eq("idle_state", 128'(dbg_state), 128'(ST_IDLE));

    // Full line write at 0x40, read back via unaligned 0x43.
    for (int b = 0; b < 4; b++) begin
      wr_data[b] = {16{8'(b + 1)}};
      wr_mask[b] = 16'hFFFF;
    end
    do_write(28'h40, 4, 0);
    do_read(28'h43);

    // Only the low 4 bytes of beat 2 change.
    for (int b = 0; b < 4; b++) begin
      wr_data[b] = '1;
      wr_mask[b] = (b == 2) ? 16'h000F : 16'h0000;
    end
    do_write(28'h40, 4, 0);
    check_eq("mask_model", model_mem[12'h042], {{12{8'h03}}, {4{8'hFF}}});
    do_read(28'h40);

    // Two idle cycles before every write beat.
    for (int b = 0; b < 4; b++) begin
      wr_data[b] = {4{$urandom}};
      wr_mask[b] = 16'hFFFF;
    end
    do_write(28'h80, 4, 2);
    do_read(28'h80);

    // Reset after the first write beat: beat 0 kept, beats 1..3 untouched.
    for (int b = 0; b < 4; b++) begin
      wr_data[b] = {$urandom, $urandom, $urandom, $urandom};
      wr_mask[b] = 16'hFFFF;
    end
    do_write(28'h80, 1, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_rdy_in_rst", 128'(mif.mem_req_rdy), 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
`ifndef MEM_RESP_BACKPRESSURE_EN
    check_eq("abort_rdy", 128'(mif.mem_req_rdy), 128'd1);
`endif
    check_eq("abort_state", 128'(dbg_state), 128'(ST_IDLE));
    do_read(28'h80);

    // Random traffic over a pool of fully initialised lines, high bits aliased.
    for (int p = 0; p < 8; p++) begin
      pool[p] = 10'($urandom_range(0, 1023));
      for (int b = 0; b < 4; b++) begin
        wr_data[b] = {$urandom, $urandom, $urandom, $urandom};
        wr_mask[b] = 16'hFFFF;
      end
      do_write({16'($urandom), pool[p], 2'b00}, 4, 0);
    end
    for (int n = 0; n < 1000; n++) begin
      logic [27:0] a;
      a = {16'($urandom), pool[$urandom_range(0, 7)], 2'($urandom)};
      if ($urandom_range(0, 1) == 0) begin
        do_read(a);
      end else begin
        for (int b = 0; b < 4; b++) begin
          wr_data[b] = {$urandom, $urandom, $urandom, $urandom};
          wr_mask[b] = 16'($urandom_range(0, 65535));
        end
        do_write(a, 4, $urandom_range(0, 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
